qpsk_demod: RTL and testbench



---
 rtl/qpsk_pkg.sv | 31 +++
 rtl/stream_fifo2.sv | 68 ++++++
 rtl/qpsk_demod.sv | 121 ++++++++++++
 tb/tb_qpsk_demod.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// rtl/qpsk_pkg.sv - shared constants, decision record and helpers for the QPSK mapper/demapper pair
package qpsk_pkg;

  // Constellation levels used by the transmit mapper: bit 0 -> +max, bit 1 -> -max
  localparam logic [15:0] QPSK_POS = 16'h7FFF;
  localparam logic [15:0] QPSK_NEG = 16'h8001;

  // Field positions inside a {Im, Re} sample word
  localparam int RE_LSB = 0;
  localparam int IM_LSB = 16;

  // One demapped symbol: dibit {Im sign, Re sign} plus low-confidence flag
  typedef struct packed {
    logic [1:0] dibit;
    logic       lc;
  } dec_t;

  // Magnitude of a two's complement value; -32768 saturates to 32767 so it stays positive
  function automatic logic [15:0] abs_sat16(input logic [15:0] x);
    logic [15:0] r;
    if (x == 16'h8000) begin
      r = 16'h7FFF;
    end else if (x[15]) begin
      r = (~x) + 16'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry first-in first-out buffer with occupancy count
module stream_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   cnt,
  output logic         valid
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_next;
  logic         valid_q;
  logic         pop_eff;

  // A pop against an empty buffer is meaningless and is ignored
  always_comb begin
    pop_eff  = pop & valid_q;
    cnt_next = cnt_q + {1'b0, push} - {1'b0, pop_eff};
  end

  // Storage shifts toward mem0, which is always the head entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0    <= '0;
      mem1    <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_next;
      valid_q <= (cnt_next != 2'd0);
      case ({push, pop_eff})
        2'b10: begin
          if (cnt_q == 2'd0) mem0 <= push_data;
          else               mem1 <= push_data;
        end
        2'b01: mem0 <= mem1;
        2'b11: begin
          if (cnt_q == 2'd1) begin
            mem0 <= push_data;
          end else begin
            mem0 <= mem1;
            mem1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Upstream only pushes into a full buffer when a pop frees a slot in the same cycle
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop_eff && cnt_q == 2'd2));
    end
  end

  assign head_data = mem0;
  assign cnt       = cnt_q;
  assign valid     = valid_q;

endmodule

// File: rtl/qpsk_demod.sv
// rtl/qpsk_demod.sv - hard-decision QPSK demapper with 3-deep elastic buffer and frame symbol count
module qpsk_demod
  import qpsk_pkg::*;
#(
  parameter logic [15:0] THRESH = 16'd1024,
  parameter int          CNT_W  = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [31:0]      DAT_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  input  logic             WE_I,
  output logic             ACK_O,
  output logic [1:0]       DAT_O,
  output logic             LC_O,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  input  logic             ACK_I,
  output logic [CNT_W-1:0] SYM_CNT_O
);

  logic             ena;
  logic             pop;
  logic             advance;
  logic             s1_val;
  logic             s1_val_next;
  logic [31:0]      s1_dat;
  logic [1:0]       fifo_cnt;
  logic [1:0]       fifo_cnt_next;
  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic             fifo_valid;
  logic             cyc_d1;
  logic             cyc_o_q;
  logic             cyc_o_next;
  logic [CNT_W-1:0] sym_cnt;
  logic [15:0]      s1_im;
  logic [15:0]      s1_re;
  dec_t             s1_dec;
  logic [2:0]       head_bits;
  dec_t             head;

  // Handshake and occupancy; ACK_O depends only on upstream inputs and registered state
  always_comb begin
    ena           = CYC_I & STB_I & WE_I;
    occ           = {1'b0, s1_val} + fifo_cnt;
    ACK_O         = ena & (occ != 2'd3);
    pop           = fifo_valid & ACK_I;
    advance       = s1_val & ((fifo_cnt != 2'd2) | pop);
    s1_val_next   = ACK_O | (s1_val & ~advance);
    fifo_cnt_next = fifo_cnt + {1'b0, advance} - {1'b0, pop};
    occ_next      = {1'b0, s1_val_next} + fifo_cnt_next;
    cyc_o_next    = cyc_d1 | (occ_next != 2'd0);
  end

  // Hard decision on the staged sample: sign bits, plus low confidence if either component is weak
  always_comb begin
    s1_im        = s1_dat[IM_LSB +: 16];
    s1_re        = s1_dat[RE_LSB +: 16];
    s1_dec.dibit = {s1_im[15], s1_re[15]};
    s1_dec.lc    = (abs_sat16(s1_re) < THRESH) | (abs_sat16(s1_im) < THRESH);
  end

  // Input stage: capture on acceptance, hold until the buffer can take it
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      s1_val <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_val <= s1_val_next;
      if (ACK_O) s1_dat <= DAT_I;
    end
  end

  stream_fifo2 #(
    .W ($bits(dec_t))
  ) u_fifo (
    .clk       (CLK_I),
    .rst_n     (RST_I),
    .push      (advance),
    .push_data (s1_dec),
    .pop       (pop),
    .head_data (head_bits),
    .cnt       (fifo_cnt),
    .valid     (fifo_valid)
  );

  assign head = dec_t'(head_bits);

  // Frame tracking: CYC_O holds until the buffer drains after CYC_I drops
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      cyc_d1  <= 1'b0;
      cyc_o_q <= 1'b0;
    end else begin
      cyc_d1  <= CYC_I;
      cyc_o_q <= cyc_o_next;
    end
  end

  // Symbol counter: restarts when a new output frame opens, counts every delivered symbol
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      sym_cnt <= '0;
    end else if (cyc_o_next & ~cyc_o_q) begin
      sym_cnt <= pop ? CNT_W'(1) : '0;
    end else if (pop) begin
      sym_cnt <= sym_cnt + CNT_W'(1);
    end
  end

  assign DAT_O     = head.dibit;
  assign LC_O      = head.lc;
  assign STB_O     = fifo_valid;
  assign WE_O      = fifo_valid;
  assign CYC_O     = cyc_o_q;
  assign SYM_CNT_O = sym_cnt;

endmodule

// File: tb/tb_qpsk_demod.sv
// tb/tb_qpsk_demod.sv - directed vector bench for the QPSK demapper
module tb_qpsk_demod;
  import qpsk_pkg::*;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [31:0] DAT_I;
  logic        CYC_I;
  logic        STB_I;
  logic        WE_I;
  logic        ACK_O;
  logic [1:0]  DAT_O;
  logic        LC_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I;
  logic [15:0] SYM_CNT_O;

  qpsk_demod #(.THRESH(16'd1024), .CNT_W(16)) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .DAT_I     (DAT_I),
    .CYC_I     (CYC_I),
    .STB_I     (STB_I),
    .WE_I      (WE_I),
    .ACK_O     (ACK_O),
    .DAT_O     (DAT_O),
    .LC_O      (LC_O),
    .CYC_O     (CYC_O),
    .STB_O     (STB_O),
    .WE_O      (WE_O),
    .ACK_I     (ACK_I),
    .SYM_CNT_O (SYM_CNT_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  d;
    logic        lc;
  } vec_t;

  vec_t vecs [0:63];
  vec_t seq4 [0:3];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK_I);
    @(negedge CLK_I);
  endtask

  // Streams vecs[0..n-1] back to back with ACK_I high; called at a negedge with the pipe empty
  task automatic run_stream(input int n, input string tag);
    ACK_I = 1'b1;
    CYC_I = 1'b1;
    WE_I  = 1'b1;
    DAT_I = vecs[0].dat;
    STB_I = 1'b1;
    #1 chk({tag, "_ack0"}, 32'(ACK_O), 32'd1);
    for (int j = 0; j <= n; j++) begin
      cyc();
      if (j >= 1) begin
        chk({tag, "_stb"}, 32'(STB_O), 32'd1);
        chk({tag, "_dat"}, 32'(DAT_O), 32'(vecs[j-1].d));
        chk({tag, "_lc"},  32'(LC_O),  32'(vecs[j-1].lc));
      end
      chk({tag, "_cnt"}, 32'(SYM_CNT_O), 32'(exp_cnt + ((j >= 1) ? j - 1 : 0)));
      if (j + 1 < n) begin
        DAT_I = vecs[j+1].dat;
        STB_I = 1'b1;
        #1 chk({tag, "_ack"}, 32'(ACK_O), 32'd1);
      end else begin
        STB_I = 1'b0;
      end
    end
    cyc();
    exp_cnt += n;
    chk({tag, "_cnt_end"}, 32'(SYM_CNT_O), 32'(exp_cnt));
    chk({tag, "_stb_end"}, 32'(STB_O), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int   k;
    int   acks;
    logic [1:0] b;

    RST_I = 1'b0;
    DAT_I = '0;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    ACK_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    chk("rst_stb",  32'(STB_O), 32'd0);
    chk("rst_cyc",  32'(CYC_O), 32'd0);
    chk("rst_cnt",  32'(SYM_CNT_O), 32'd0);
    chk("rst_dat",  32'(DAT_O), 32'd0);
    chk("rst_ack",  32'(ACK_O), 32'd0);
    RST_I = 1'b1;
    cyc();
    chk("idle_stb", 32'(STB_O), 32'd0);

    // Directed decision table
    vecs[0]  = '{dat: 32'h7FFF7FFF, d: 2'b00, lc: 1'b0};
    vecs[1]  = '{dat: 32'h80017FFF, d: 2'b10, lc: 1'b0};
    vecs[2]  = '{dat: 32'h7FFF8001, d: 2'b01, lc: 1'b0};
    vecs[3]  = '{dat: 32'h80018001, d: 2'b11, lc: 1'b0};
    vecs[4]  = '{dat: 32'h7FFF0100, d: 2'b00, lc: 1'b1};
    vecs[5]  = '{dat: 32'h7FFF8000, d: 2'b01, lc: 1'b0};
    vecs[6]  = '{dat: 32'h00000000, d: 2'b00, lc: 1'b1};
    vecs[7]  = '{dat: 32'h0400FC00, d: 2'b01, lc: 1'b0};
    vecs[8]  = '{dat: 32'h03FF7FFF, d: 2'b00, lc: 1'b1};
    vecs[9]  = '{dat: 32'hFC018000, d: 2'b11, lc: 1'b1};
    vecs[10] = '{dat: 32'h80008000, d: 2'b11, lc: 1'b0};
    run_stream(11, "table");

    // Loopback through a transmit mapper model
    for (int i = 0; i < 64; i++) begin
      b = 2'($urandom_range(0, 3));
      vecs[i].dat = {(b[1] ? QPSK_NEG : QPSK_POS), (b[0] ? QPSK_NEG : QPSK_POS)};
      vecs[i].d   = b;
      vecs[i].lc  = 1'b0;
    end
    run_stream(64, "loop");

    // Backpressure: exactly three samples fit, then they drain in order
    seq4[0] = '{dat: 32'h80017FFF, d: 2'b10, lc: 1'b0};
    seq4[1] = '{dat: 32'h7FFF8001, d: 2'b01, lc: 1'b0};
    seq4[2] = '{dat: 32'h80018001, d: 2'b11, lc: 1'b0};
    seq4[3] = '{dat: 32'h7FFF7FFF, d: 2'b00, lc: 1'b0};
    ACK_I = 1'b0;
    STB_I = 1'b1;
    k     = 0;
    acks  = 0;
    DAT_I = seq4[0].dat;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ACK_O) begin
        acks++;
        k++;
      end
      cyc();
      if (k < 4) DAT_I = seq4[k].dat;
    end
    chk("bp_acks", 32'(acks), 32'd3);
    #1 chk("bp_ack_low", 32'(ACK_O), 32'd0);
    STB_I = 1'b0;
    ACK_I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stb", 32'(STB_O), 32'd1);
      chk("bp_dat", 32'(DAT_O), 32'(seq4[i].d));
      cyc();
    end
    chk("bp_empty", 32'(STB_O), 32'd0);
    exp_cnt += 3;
    chk("bp_cnt", 32'(SYM_CNT_O), 32'(exp_cnt));
    STB_I = 1'b1;
    DAT_I = seq4[3].dat;
    #1 chk("bp_resume", 32'(ACK_O), 32'd1);
    cyc();
    STB_I = 1'b0;
    cyc();
    chk("bp_resume_dat", 32'(DAT_O), 32'(seq4[3].d));
    cyc();
    exp_cnt += 1;
    chk("bp_resume_cnt", 32'(SYM_CNT_O), 32'(exp_cnt));

    // Frame end: CYC_O holds until the buffer drains, new frame restarts the count
    ACK_I = 1'b0;
    STB_I = 1'b1;
    DAT_I = seq4[0].dat;
    cyc();
    DAT_I = seq4[2].dat;
    cyc();
    STB_I = 1'b0;
    cyc();
    CYC_I = 1'b0;
    cyc();
    cyc();
    chk("fe_cyc_hold", 32'(CYC_O), 32'd1);
    chk("fe_stb", 32'(STB_O), 32'd1);
    ACK_I = 1'b1;
    cyc();
    chk("fe_cyc_1", 32'(CYC_O), 32'd1);
    ACK_I = 1'b0;
    cyc();
    chk("fe_cyc_2", 32'(CYC_O), 32'd1);
    chk("fe_dat_last", 32'(DAT_O), 32'(seq4[2].d));
    ACK_I = 1'b1;
    cyc();
    chk("fe_cyc_fall", 32'(CYC_O), 32'd0);
    chk("fe_stb_fall", 32'(STB_O), 32'd0);
    exp_cnt += 2;
    chk("fe_cnt", 32'(SYM_CNT_O), 32'(exp_cnt));
    CYC_I = 1'b1;
    STB_I = 1'b1;
    DAT_I = seq4[1].dat;
    cyc();
    STB_I = 1'b0;
    chk("nf_cyc", 32'(CYC_O), 32'd1);
    chk("nf_cnt_clr", 32'(SYM_CNT_O), 32'd0);
    cyc();
    cyc();
    chk("nf_cnt_1", 32'(SYM_CNT_O), 32'd1);

    // Asynchronous reset with the buffer full
    ACK_I = 1'b0;
    STB_I = 1'b1;
    DAT_I = 32'h80018001;
    repeat (3) cyc();
    #1 chk("ar_full", 32'(ACK_O), 32'd0);
    STB_I = 1'b0;
    chk("ar_pre_dat", 32'(DAT_O), 32'd3);
    #1 RST_I = 1'b0;
    #1;
    chk("ar_stb", 32'(STB_O), 32'd0);
    chk("ar_we",  32'(WE_O), 32'd0);
    chk("ar_cyc", 32'(CYC_O), 32'd0);
    chk("ar_dat", 32'(DAT_O), 32'd0);
    chk("ar_lc",  32'(LC_O), 32'd0);
    chk("ar_cnt", 32'(SYM_CNT_O), 32'd0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    ACK_I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ar_no_stale", 32'(STB_O), 32'd0);
    end
    STB_I = 1'b1;
    DAT_I = 32'h7FFF8001;
    cyc();
    STB_I = 1'b0;
    cyc();
    chk("ar_fresh_stb", 32'(STB_O), 32'd1);
    chk("ar_fresh_dat", 32'(DAT_O), 32'd1);
    chk("ar_fresh_lc",  32'(LC_O), 32'd0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
